pid_sequencer: RTL and testbench

Frame-level controller for the three per-axis rate PID units (roll, pitch, yaw). On each new IMU sample strobe it freezes a snapshot of every axis's target, actual and angle-error inputs. It then launches all three PIDs with one shared start pulse and collects their completion handshakes, bounded by a watchdog. Finally it captures the three rate outputs, releases the PIDs back to their wait state, and presents one registered, validated rate triple to the motor mixer.

---
 rtl/pid_seq_pkg.sv | 27 ++
 rtl/pid_seq_if.sv | 67 ++++++
 rtl/pid_seq_watchdog.sv | 46 ++++
 rtl/pid_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_pid_sequencer.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pid_seq_pkg.sv
// ============================================================================
// Package     : pid_seq_pkg
// Description : Shared types and constants for the PID frame sequencer:
//               one-hot state encoding, axis count and axis bit indices.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pid_seq_pkg;

    localparam int NUM_AXES   = 3;
    localparam int AXIS_ROLL  = 0;
    localparam int AXIS_PITCH = 1;
    localparam int AXIS_YAW   = 2;

    // One-hot frame states
    typedef enum logic [4:0] {
        ST_IDLE    = 5'b00001,
        ST_START   = 5'b00010,
        ST_RUN     = 5'b00100,
        ST_RELEASE = 5'b01000,
        ST_DRAIN   = 5'b10000
    } seq_state_e;

endpackage

`default_nettype wire

// File: rtl/pid_seq_if.sv
// ============================================================================
// Interface   : pid_seq_if
// Description : Bundle between the frame sequencer (slave), the IMU/mixer
//               side and the three rate PIDs (master side).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pid_seq_if
    import pid_seq_pkg::*;
#(
    parameter int RATE_BIT_WIDTH    = 16,
    parameter int IMU_VAL_BIT_WIDTH = 16
);
    logic                                sample_strobe;
    logic                                err_clear;
    logic signed [RATE_BIT_WIDTH-1:0]    roll_target,  pitch_target,  yaw_target;
    logic signed [IMU_VAL_BIT_WIDTH-1:0] roll_actual,  pitch_actual,  yaw_actual;
    logic signed [RATE_BIT_WIDTH-1:0]    roll_angle_err, pitch_angle_err, yaw_angle_err;
    logic [NUM_AXES-1:0]                 pid_active;
    logic [NUM_AXES-1:0]                 pid_complete;
    logic signed [RATE_BIT_WIDTH-1:0]    roll_rate_in, pitch_rate_in, yaw_rate_in;

    logic signed [RATE_BIT_WIDTH-1:0]    roll_target_q,  pitch_target_q,  yaw_target_q;
    logic signed [IMU_VAL_BIT_WIDTH-1:0] roll_actual_q,  pitch_actual_q,  yaw_actual_q;
    logic signed [RATE_BIT_WIDTH-1:0]    roll_angle_err_q, pitch_angle_err_q, yaw_angle_err_q;
    logic                                start_flag;
    logic                                wait_flag;
    logic signed [RATE_BIT_WIDTH-1:0]    roll_rate_out, pitch_rate_out, yaw_rate_out;
    logic                                rates_valid;
    logic                                busy;
    logic                                overrun;
    logic                                timeout_err;

    modport master (
        output sample_strobe, err_clear,
               roll_target, pitch_target, yaw_target,
               roll_actual, pitch_actual, yaw_actual,
               roll_angle_err, pitch_angle_err, yaw_angle_err,
               pid_active, pid_complete,
               roll_rate_in, pitch_rate_in, yaw_rate_in,
        input  roll_target_q, pitch_target_q, yaw_target_q,
               roll_actual_q, pitch_actual_q, yaw_actual_q,
               roll_angle_err_q, pitch_angle_err_q, yaw_angle_err_q,
               start_flag, wait_flag,
               roll_rate_out, pitch_rate_out, yaw_rate_out,
               rates_valid, busy, overrun, timeout_err
    );

    modport slave (
        input  sample_strobe, err_clear,
               roll_target, pitch_target, yaw_target,
               roll_actual, pitch_actual, yaw_actual,
               roll_angle_err, pitch_angle_err, yaw_angle_err,
               pid_active, pid_complete,
               roll_rate_in, pitch_rate_in, yaw_rate_in,
        output roll_target_q, pitch_target_q, yaw_target_q,
               roll_actual_q, pitch_actual_q, yaw_actual_q,
               roll_angle_err_q, pitch_angle_err_q, yaw_angle_err_q,
               start_flag, wait_flag,
               roll_rate_out, pitch_rate_out, yaw_rate_out,
               rates_valid, busy, overrun, timeout_err
    );

endinterface

`default_nettype wire

// File: rtl/pid_seq_watchdog.sv
// ============================================================================
// Module      : pid_seq_watchdog
// Description : Clearable saturating cycle counter; expired_o is high while
//               the count sits at LIMIT.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pid_seq_watchdog #(
    parameter int LIMIT = 64
) (
    input  logic us_clk,
    input  logic resetn,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int                  c_CNT_W = $clog2(LIMIT + 1);
    localparam logic [c_CNT_W-1:0]  c_LIMIT = c_CNT_W'(LIMIT);

    logic [c_CNT_W-1:0] cnt_q, cnt_d;

    // Next count: clear wins, otherwise count up and stick at LIMIT
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != c_LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge us_clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == c_LIMIT);

endmodule

`default_nettype wire

// File: rtl/pid_sequencer.sv
// ============================================================================
// Module      : pid_sequencer
// Description : Frame controller for the roll/pitch/yaw rate PIDs. Snapshots
//               inputs on an IMU strobe, starts all PIDs, collects their
//               done handshakes, captures the rates and releases the PIDs.
// Config      : PID_SEQ_WATCHDOG_EN - when defined, a watchdog bounds the
//               RUN and DRAIN states and drives timeout_err.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pid_sequencer
    import pid_seq_pkg::*;
#(
    parameter int RATE_BIT_WIDTH    = 16,
    parameter int IMU_VAL_BIT_WIDTH = 16,
    parameter int TIMEOUT_CYCLES    = 64
) (
    input  logic     us_clk,
    input  logic     resetn,
    pid_seq_if.slave bus
);
    typedef logic signed [RATE_BIT_WIDTH-1:0]    rate_t;
    typedef logic signed [IMU_VAL_BIT_WIDTH-1:0] imu_t;

    rate_t w_tgt_live [NUM_AXES];
    imu_t  w_act_live [NUM_AXES];
    rate_t w_aerr_live[NUM_AXES];
    rate_t w_rate_live[NUM_AXES];
    rate_t tgt_q      [NUM_AXES];
    imu_t  act_q      [NUM_AXES];
    rate_t aerr_q     [NUM_AXES];
    rate_t rate_q     [NUM_AXES];

    seq_state_e          state_q, state_d;
    logic [NUM_AXES-1:0] done_q, done_d;
    logic                rates_valid_q;
    logic                overrun_q;
    logic                w_pid_idle, w_accept, w_capture;
    logic                w_timeout_set, w_wd_clear, w_wd_en, w_wd_expired;

    assign w_tgt_live[AXIS_ROLL]   = bus.roll_target;
    assign w_tgt_live[AXIS_PITCH]  = bus.pitch_target;
    assign w_tgt_live[AXIS_YAW]    = bus.yaw_target;
    assign w_act_live[AXIS_ROLL]   = bus.roll_actual;
    assign w_act_live[AXIS_PITCH]  = bus.pitch_actual;
    assign w_act_live[AXIS_YAW]    = bus.yaw_actual;
    assign w_aerr_live[AXIS_ROLL]  = bus.roll_angle_err;
    assign w_aerr_live[AXIS_PITCH] = bus.pitch_angle_err;
    assign w_aerr_live[AXIS_YAW]   = bus.yaw_angle_err;
    assign w_rate_live[AXIS_ROLL]  = bus.roll_rate_in;
    assign w_rate_live[AXIS_PITCH] = bus.pitch_rate_in;
    assign w_rate_live[AXIS_YAW]   = bus.yaw_rate_in;

    // A strobe is only taken when idle and every PID is back in its wait state
    assign w_pid_idle = (bus.pid_active == '0);
    assign w_accept   = bus.sample_strobe && (state_q == ST_IDLE) && w_pid_idle;

    // State and sticky done-bit registers
    always_ff @(posedge us_clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    // Next-state and per-state control; pid_complete alone is not "done"
    // because a PID also shows complete while parked in its wait state
    always_comb begin
        state_d       = state_q;
        done_d        = done_q;
        w_capture     = 1'b0;
        w_timeout_set = 1'b0;
        w_wd_clear    = 1'b0;
        w_wd_en       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_accept) state_d = ST_START;
            end
            ST_START: begin
                done_d     = '0;
                w_wd_clear = 1'b1;
                state_d    = ST_RUN;
            end
            ST_RUN: begin
                w_wd_en = 1'b1;
                done_d  = done_q | (bus.pid_active & bus.pid_complete);
                if (&done_q) begin
                    w_capture = 1'b1;
                    state_d   = ST_RELEASE;
                end else if (w_wd_expired) begin
                    w_timeout_set = 1'b1;
                    state_d       = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                w_wd_clear = 1'b1;
                state_d    = ST_DRAIN;
            end
            ST_DRAIN: begin
                w_wd_en = 1'b1;
                if (w_pid_idle) begin
                    state_d = ST_IDLE;
                end else if (w_wd_expired) begin
                    w_timeout_set = 1'b1;
                    state_d       = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Snapshot registers: held until the next accepted strobe since the
    // PIDs read them live for the whole frame
    always_ff @(posedge us_clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_AXES; i++) begin
                tgt_q[i]  <= '0;
                act_q[i]  <= '0;
                aerr_q[i] <= '0;
            end
        end else if (w_accept) begin
            for (int i = 0; i < NUM_AXES; i++) begin
                tgt_q[i]  <= w_tgt_live[i];
                act_q[i]  <= w_act_live[i];
                aerr_q[i] <= w_aerr_live[i];
            end
        end
    end

    // Rate capture and its one-cycle valid pulse
    always_ff @(posedge us_clk or negedge resetn) begin
        if (!resetn) begin
            rates_valid_q <= 1'b0;
            for (int i = 0; i < NUM_AXES; i++) rate_q[i] <= '0;
        end else begin
            rates_valid_q <= w_capture;
            if (w_capture) begin
                for (int i = 0; i < NUM_AXES; i++) rate_q[i] <= w_rate_live[i];
            end
        end
    end

    // Sticky overrun: any strobe not accepted was dropped; set beats clear
    always_ff @(posedge us_clk or negedge resetn) begin
        if (!resetn) begin
            overrun_q <= 1'b0;
        end else if (bus.sample_strobe && !w_accept) begin
            overrun_q <= 1'b1;
        end else if (bus.err_clear) begin
            overrun_q <= 1'b0;
        end
    end

`ifdef PID_SEQ_WATCHDOG_EN
    logic timeout_err_q;

    pid_seq_watchdog #(
        .LIMIT     (TIMEOUT_CYCLES)
    ) u_watchdog (
        .us_clk    (us_clk),
        .resetn    (resetn),
        .clear_i   (w_wd_clear),
        .en_i      (w_wd_en),
        .expired_o (w_wd_expired)
    );

    // Sticky timeout flag; set beats clear
    always_ff @(posedge us_clk or negedge resetn) begin
        if (!resetn) begin
            timeout_err_q <= 1'b0;
        end else if (w_timeout_set) begin
            timeout_err_q <= 1'b1;
        end else if (bus.err_clear) begin
            timeout_err_q <= 1'b0;
        end
    end

    assign bus.timeout_err = timeout_err_q;
`else
    // No watchdog: RUN and DRAIN wait on the handshakes alone
    logic w_unused_wd;
    assign w_wd_expired    = 1'b0;
    assign w_unused_wd     = w_wd_clear ^ w_wd_en ^ w_timeout_set ^ (TIMEOUT_CYCLES > 0);
    assign bus.timeout_err = 1'b0;
`endif

    assign bus.roll_target_q     = tgt_q[AXIS_ROLL];
    assign bus.pitch_target_q    = tgt_q[AXIS_PITCH];
    assign bus.yaw_target_q      = tgt_q[AXIS_YAW];
    assign bus.roll_actual_q     = act_q[AXIS_ROLL];
    assign bus.pitch_actual_q    = act_q[AXIS_PITCH];
    assign bus.yaw_actual_q      = act_q[AXIS_YAW];
    assign bus.roll_angle_err_q  = aerr_q[AXIS_ROLL];
    assign bus.pitch_angle_err_q = aerr_q[AXIS_PITCH];
    assign bus.yaw_angle_err_q   = aerr_q[AXIS_YAW];
    assign bus.roll_rate_out     = rate_q[AXIS_ROLL];
    assign bus.pitch_rate_out    = rate_q[AXIS_PITCH];
    assign bus.yaw_rate_out      = rate_q[AXIS_YAW];
    assign bus.rates_valid       = rates_valid_q;
    assign bus.overrun           = overrun_q;
    assign bus.start_flag        = (state_q == ST_START);
    assign bus.wait_flag         = (state_q == ST_RELEASE);
    assign bus.busy              = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_pid_sequencer.sv
// ============================================================================
// Module      : tb_pid_sequencer
// Description : Directed self-checking bench for pid_sequencer with three
//               behavioural fixed-latency PID models.
// Config      : PID_SEQ_WATCHDOG_EN selects the timeout expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pid_sequencer;
    localparam int c_TMO = 64;

    logic us_clk;
    logic resetn;
    int   n_total = 0;
    int   n_bad   = 0;
    int   ov_at[128];
    int   to_at[128];

    pid_seq_if #(.RATE_BIT_WIDTH(16), .IMU_VAL_BIT_WIDTH(16)) bus ();

    pid_sequencer #(
        .RATE_BIT_WIDTH    (16),
        .IMU_VAL_BIT_WIDTH (16),
        .TIMEOUT_CYCLES    (c_TMO)
    ) dut (
        .us_clk (us_clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    initial us_clk = 1'b0;
    always #5 us_clk = ~us_clk;

    // ---------------- PID models ----------------
    // state: 0 wait, 1 calc, 2 complete, 3 releasing
    int                 st[3];
    int                 cnt[3];
    int                 lat[3];
    bit                 never[3];
    logic [2:0]         m_act, m_cmp;
    logic signed [15:0] m_rate[3];
    logic signed [15:0] tq[3];
    logic signed [15:0] aq[3];

    assign tq[0] = bus.roll_target_q;
    assign tq[1] = bus.pitch_target_q;
    assign tq[2] = bus.yaw_target_q;
    assign aq[0] = bus.roll_actual_q;
    assign aq[1] = bus.pitch_actual_q;
    assign aq[2] = bus.yaw_actual_q;
    assign bus.pid_active    = m_act;
    assign bus.pid_complete  = m_cmp;
    assign bus.roll_rate_in  = m_rate[0];
    assign bus.pitch_rate_in = m_rate[1];
    assign bus.yaw_rate_in   = m_rate[2];

    always @(posedge us_clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 3; i++) begin
                st[i] <= 0; cnt[i] <= 0; m_act[i] <= 1'b0; m_cmp[i] <= 1'b1; m_rate[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                case (st[i])
                    0: if (bus.start_flag) begin
                           st[i] <= 1; cnt[i] <= 1; m_act[i] <= 1'b1; m_cmp[i] <= 1'b0;
                       end
                    1: if (bus.wait_flag) st[i] <= 3;
                       else if (!never[i] && cnt[i] == lat[i]) begin
                           st[i] <= 2; m_cmp[i] <= 1'b1; m_rate[i] <= tq[i] - aq[i];
                       end else cnt[i] <= cnt[i] + 1;
                    2: if (bus.wait_flag) st[i] <= 3;
                    default: begin st[i] <= 0; m_act[i] <= 1'b0; m_cmp[i] <= 1'b1; end
                endcase
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic set_live(input int r, input int p, input int y, input int ra);
        bus.roll_target  = 16'(r);
        bus.pitch_target = 16'(p);
        bus.yaw_target   = 16'(y);
        bus.roll_actual  = 16'(ra);
    endtask

    // Strobe in cycle 0, then step until back in IDLE or the budget runs out.
    // xs: cycle of an extra strobe (changes live targets); c1/c2: err_clear cycles.
    task automatic run_frame(input int budget, input int xs, input int c1, input int c2,
                             output int t_start, output int t_valid,
                             output int t_wait, output int t_idle);
        t_start = -1; t_valid = -1; t_wait = -1; t_idle = -1;
        bus.sample_strobe = 1'b1;
        for (int k = 1; k <= budget; k++) begin
            @(posedge us_clk); #1;
            if (k < 128) begin
                ov_at[k] = int'(bus.overrun);
                to_at[k] = int'(bus.timeout_err);
            end
            if (t_start < 0 && bus.start_flag)  t_start = k;
            if (t_valid < 0 && bus.rates_valid) t_valid = k;
            if (t_wait  < 0 && bus.wait_flag)   t_wait  = k;
            if (t_idle  < 0 && t_start >= 0 && !bus.busy) t_idle = k;
            bus.sample_strobe = (k == xs);
            if (k == xs) set_live(1, 2, 3, 0);
            bus.err_clear = (k == c1) || (k == c2);
            if (t_idle >= 0) break;
        end
        bus.sample_strobe = 1'b0;
        bus.err_clear     = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    int ts, tv, tw, ti;

    initial begin
        resetn = 1'b0;
        bus.sample_strobe = 1'b0;
        bus.err_clear     = 1'b0;
        set_live(0, 0, 0, 0);
        bus.pitch_actual = '0;
        bus.yaw_actual   = '0;
        bus.roll_angle_err  = 16'sd11;
        bus.pitch_angle_err = 16'sd22;
        bus.yaw_angle_err   = 16'sd33;
        for (int i = 0; i < 3; i++) begin lat[i] = 4; never[i] = 1'b0; end
        repeat (3) @(posedge us_clk);
        #1;
        chk("rst_busy",        int'(bus.busy),        0);
        chk("rst_start_flag",  int'(bus.start_flag),  0);
        chk("rst_wait_flag",   int'(bus.wait_flag),   0);
        chk("rst_rates_valid", int'(bus.rates_valid), 0);
        chk("rst_overrun",     int'(bus.overrun),     0);
        chk("rst_timeout_err", int'(bus.timeout_err), 0);
        chk("rst_roll_rate",   int'(bus.roll_rate_out),   0);
        chk("rst_pitch_tgt_q", int'(bus.pitch_target_q),  0);
        resetn = 1'b1;
        @(posedge us_clk); #1;

        // Nominal frame
        set_live(100, -50, 7, 0);
        run_frame(20, -1, -1, -1, ts, tv, tw, ti);
        chk("t1_start_cyc", ts, 1);
        chk("t1_valid_cyc", tv, 8);
        chk("t1_wait_cyc",  tw, 8);
        chk("t1_idle_cyc",  ti, 11);
        chk("t1_roll_rate",  int'(bus.roll_rate_out),  100);
        chk("t1_pitch_rate", int'(bus.pitch_rate_out), -50);
        chk("t1_yaw_rate",   int'(bus.yaw_rate_out),   7);
        chk("t1_yaw_aerr_q", int'(bus.yaw_angle_err_q), 33);
        chk("t1_overrun",    int'(bus.overrun), 0);

        // Extra strobe in cycle 5 is dropped, snapshot untouched
        run_frame(20, 5, -1, -1, ts, tv, tw, ti);
        chk("t2_ovr_before", ov_at[5], 0);
        chk("t2_ovr_after",  ov_at[6], 1);
        chk("t2_valid_cyc",  tv, 8);
        chk("t2_idle_cyc",   ti, 11);
        chk("t2_roll_tgt_q", int'(bus.roll_target_q), 100);
        chk("t2_yaw_tgt_q",  int'(bus.yaw_target_q),  7);
        chk("t2_roll_rate",  int'(bus.roll_rate_out), 100);
        chk("t2_overrun",    int'(bus.overrun), 1);

        // err_clear with a dropped strobe: set wins; clear alone next cycle
        run_frame(20, 3, 3, 4, ts, tv, tw, ti);
        chk("t5_set_wins",   ov_at[4], 1);
        chk("t5_cleared",    ov_at[5], 0);
        chk("t5_roll_tgt_q", int'(bus.roll_target_q), 1);
        chk("t5_yaw_rate",   int'(bus.yaw_rate_out),  3);

        // Roll completes 3 cycles late
        set_live(-8, 9, 10, 5);
        lat[0] = 7;
        run_frame(30, -1, -1, -1, ts, tv, tw, ti);
        chk("t4_valid_cyc",  tv, 11);
        chk("t4_wait_cyc",   tw, 11);
        chk("t4_idle_cyc",   ti, 14);
        chk("t4_roll_act_q", int'(bus.roll_actual_q), 5);
        chk("t4_roll_rate",  int'(bus.roll_rate_out), -13);
        chk("t4_pitch_rate", int'(bus.pitch_rate_out), 9);
        lat[0] = 4;

        // Yaw never completes
        never[2] = 1'b1;
        run_frame(100, -1, -1, -1, ts, tv, tw, ti);
        chk("t3_start_cyc", ts, 1);
        chk("t3_no_valid",  tv, -1);
`ifdef PID_SEQ_WATCHDOG_EN
        chk("t3_wait_cyc",  tw, c_TMO + 3);
        chk("t3_idle_cyc",  ti, c_TMO + 6);
        chk("t3_tmo_early", to_at[c_TMO + 2], 0);
        chk("t3_tmo_set",   to_at[c_TMO + 3], 1);
`else
        chk("t3_no_wait",   tw, -1);
        chk("t3_stuck",     ti, -1);
        chk("t3_tmo_tied",  to_at[c_TMO + 3], 0);
`endif
        chk("t3_roll_rate", int'(bus.roll_rate_out), -13);
        chk("t3_yaw_rate",  int'(bus.yaw_rate_out),  10);

        // Reset asserted while in RUN
        never[2] = 1'b0;
`ifdef PID_SEQ_WATCHDOG_EN
        bus.sample_strobe = 1'b1;
        @(posedge us_clk); #1;
        bus.sample_strobe = 1'b0;
        repeat (2) @(posedge us_clk);
        #1;
`endif
        chk("t6_busy_before", int'(bus.busy), 1);
        #2 resetn = 1'b0;
        #1;
        chk("t6_busy",        int'(bus.busy),          0);
        chk("t6_start_flag",  int'(bus.start_flag),    0);
        chk("t6_wait_flag",   int'(bus.wait_flag),     0);
        chk("t6_rates_valid", int'(bus.rates_valid),   0);
        chk("t6_timeout_err", int'(bus.timeout_err),   0);
        chk("t6_overrun",     int'(bus.overrun),       0);
        chk("t6_roll_rate",   int'(bus.roll_rate_out), 0);
        chk("t6_yaw_rate",    int'(bus.yaw_rate_out),  0);
        chk("t6_pitch_tgt_q", int'(bus.pitch_target_q), 0);
        chk("t6_roll_act_q",  int'(bus.roll_actual_q),  0);
        @(posedge us_clk); #1;
        resetn = 1'b1;
        @(posedge us_clk); #1;
        run_frame(20, -1, -1, -1, ts, tv, tw, ti);
        chk("t6_start_cyc", ts, 1);
        chk("t6_valid_cyc", tv, 8);
        chk("t6_roll_rate_new", int'(bus.roll_rate_out), -13);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls
    initial begin
        #200000;
        $display("FAIL global_timeout: got=stalled expected=finish");
        $fatal(1, "simulation time limit");
    end

endmodule

`default_nettype wire
